mul_err_monitor: RTL

Streaming hardware error-statistics monitor for the approximate multipliers in this tree. It consumes operand pairs plus the approximate product produced by the device under evaluation and computes the exact fixed-point product internally. It accumulates the error statistics the simulation flow reports: error sum, squared-error sum, absolute-reference sum and exact-match count. It sits on the consuming side of a multiplier under evaluation, so error characterization runs on FPGA at full sample rates.

---
 rtl/mul_err_pkg.sv | 11 +
 rtl/mul_err_stage.sv | 22 ++
 rtl/mul_err_monitor.sv | 94 +++++++++
 3 files changed

// File: rtl/mul_err_pkg.sv
// mul_err_pkg: default widths and FSM state type shared by the error monitor.
package mul_err_pkg;
    localparam int DEF_IN_W      = 16;
    localparam int DEF_SHIFT_W   = 8;
    localparam int DEF_OUT_W     = 32;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_ERR_SUM_W = DEF_OUT_W + DEF_CNT_W + 1;
    localparam int DEF_ABS_SUM_W = DEF_OUT_W + DEF_CNT_W;
    localparam int SQ_SUM_W      = 64;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mul_err_stage.sv
// mul_err_stage: combinational S2 math, exact shifted product and its error terms.
module mul_err_stage import mul_err_pkg::*; #(
    parameter int PW      = 2 * DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic signed [PW-1:0]      prod,
    input  logic signed [OUT_W-1:0]   appr,
    output logic signed [OUT_W-1:0]   precise,
    output logic signed [OUT_W:0]     err,
    output logic [2*OUT_W+1:0]        err_sq,
    output logic [OUT_W:0]            abs_ref
);
    localparam int SQ_W = 2 * OUT_W + 2;
    always_comb begin
        precise = OUT_W'(prod >>> SHIFT_W);
        err     = {appr[OUT_W-1], appr} - {precise[OUT_W-1], precise};
        err_sq  = $unsigned(SQ_W'(err) * SQ_W'(err));
        // one extra bit so the most negative value has a representable magnitude
        abs_ref = precise[OUT_W-1] ? -{1'b1, precise} : {1'b0, precise};
    end
endmodule

// File: rtl/mul_err_monitor.sv
// mul_err_monitor: streaming error statistics of an approximate multiplier against the exact product.
module mul_err_monitor import mul_err_pkg::*; #(
    parameter int IN_W    = DEF_IN_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_samples,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_W-1:0]      in_a,
    input  logic signed [IN_W-1:0]      in_b,
    input  logic signed [OUT_W-1:0]     in_appr,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            sample_cnt,
    output logic [CNT_W-1:0]            same_cnt,
    output logic signed [OUT_W+CNT_W:0] err_sum,
    output logic [SQ_SUM_W-1:0]         err_sq_sum,
    output logic [OUT_W+CNT_W-1:0]      abs_ref_sum
);
    localparam int PW    = (2 * IN_W > OUT_W) ? 2 * IN_W : OUT_W;
    localparam int SQ_W  = 2 * OUT_W + 2;
    localparam int SQX_W = ((SQ_W > SQ_SUM_W) ? SQ_W : SQ_SUM_W) + 1;
    state_t state, state_nx;
    logic [CNT_W-1:0] num_r, acc_cnt;
    logic v1;
    logic signed [PW-1:0] prod_r;
    logic signed [OUT_W-1:0] appr_r, precise;
    logic signed [OUT_W:0] err;
    logic [SQ_W-1:0] err_sq;
    logic [OUT_W:0] abs_ref;
    logic [SQX_W-1:0] sq_sum_x;
    logic go, accept;
    assign go       = start && state != RUN;
    assign accept   = in_valid && in_ready;
    assign sq_sum_x = SQX_W'(err_sq_sum) + SQX_W'(err_sq);
    mul_err_stage #(.PW(PW), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_stage (
        .prod(prod_r), .appr(appr_r), .precise(precise),
        .err(err), .err_sq(err_sq), .abs_ref(abs_ref)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = go ? ((num_samples == '0) ? DONE : RUN)
                 : (state == RUN && sample_cnt == num_r) ? DONE : state;
    end
    always_comb begin
        busy     = state == RUN;
        done     = state == DONE;
        in_ready = state == RUN && acc_cnt < num_r;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            prod_r      <= '0;
            appr_r      <= '0;
            num_r       <= '0;
            acc_cnt     <= '0;
            sample_cnt  <= '0;
            same_cnt    <= '0;
            err_sum     <= '0;
            err_sq_sum  <= '0;
            abs_ref_sum <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                prod_r  <= PW'(in_a) * PW'(in_b);
                appr_r  <= in_appr;
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (go) begin
                num_r       <= num_samples;
                acc_cnt     <= '0;
                sample_cnt  <= '0;
                same_cnt    <= '0;
                err_sum     <= '0;
                err_sq_sum  <= '0;
                abs_ref_sum <= '0;
            end else if (v1) begin
                sample_cnt  <= sample_cnt + CNT_W'(1);
                same_cnt    <= same_cnt + CNT_W'(appr_r == precise);
                err_sum     <= err_sum + (OUT_W + CNT_W + 1)'(err);
                err_sq_sum  <= (|sq_sum_x[SQX_W-1:SQ_SUM_W]) ? '1 : sq_sum_x[SQ_SUM_W-1:0];
                abs_ref_sum <= abs_ref_sum + (OUT_W + CNT_W)'(abs_ref);
            end
        end
    end
endmodule
